// File: rtl/led_sequencer.sv
// Bus-mapped LED sequencer: shows a CPU-written value when idle. When enabled,
// it steps through a 4-entry pattern table on a programmable timer.
module led_sequencer #(
  parameter int          PERIOD_W  = 24,
  parameter logic [3:0]  RESET_LED = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rstrb,
  input  logic        wstrb,
  input  logic        sel,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [3:0]  LED,
  output logic        irq
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t              state_q;
  logic                en_q;
  logic                oneshot_q;
  logic [1:0]          last_q;
  logic [1:0]          step_q;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] cnt_q;
  logic [15:0]         pattern_q;
  logic [3:0]          manual_q;
  logic [3:0]          led_q;
  logic                done_q;

  logic        wr_ctrl, wr_period, wr_pattern, wr_manual, rd_ctrl;
  logic [15:0] pattern_d;
  logic [3:0]  manual_d;
  logic [1:0]  step_adv;
  logic        last_step;
  logic        unused_wdata;

  assign wr_ctrl    = sel & wstrb & (addr == 2'd0);
  assign wr_period  = sel & wstrb & (addr == 2'd1);
  assign wr_pattern = sel & wstrb & (addr == 2'd2);
  assign wr_manual  = sel & wstrb & (addr == 2'd3);
  assign rd_ctrl    = sel & rstrb & (addr == 2'd0);

  // Writes landing on this edge are visible to the LED update of the same edge.
  assign pattern_d = wr_pattern ? wdata[15:0] : pattern_q;
  assign manual_d  = wr_manual  ? wdata[3:0]  : manual_q;

  assign last_step = (step_q >= last_q);
  assign step_adv  = last_step ? 2'd0 : step_q + 2'd1;

  assign unused_wdata = ^wdata;

  function automatic logic [3:0] nibble(input logic [15:0] p, input logic [1:0] k);
    return p[4*k +: 4];
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      en_q      <= 1'b0;
      oneshot_q <= 1'b0;
      last_q    <= 2'd3;
      step_q    <= 2'd0;
      period_q  <= '1;
      cnt_q     <= '0;
      pattern_q <= 16'h8421;
      manual_q  <= RESET_LED;
      led_q     <= RESET_LED;
      done_q    <= 1'b0;
    end else begin
      if (wr_period) period_q <= wdata[PERIOD_W-1:0];
      pattern_q <= pattern_d;
      manual_q  <= manual_d;
      if (rd_ctrl) done_q <= 1'b0;

      if (wr_ctrl) begin
        en_q      <= wdata[0];
        oneshot_q <= wdata[1];
        last_q    <= wdata[5:4];
        if (wdata[0]) begin
          state_q <= RUN;
          step_q  <= 2'd0;
          cnt_q   <= '0;
          done_q  <= 1'b0;
          led_q   <= pattern_d[3:0];
        end else begin
          state_q <= IDLE;
          led_q   <= manual_d;
        end
      end else begin
        case (state_q)
          IDLE: led_q <= manual_d;
          RUN: begin
            // >= so that shrinking PERIOD mid-step ends the step at once
            if (cnt_q >= period_q) begin
              cnt_q <= '0;
              if (last_step && oneshot_q) begin
                state_q <= HOLD;
                en_q    <= 1'b0;
                done_q  <= 1'b1;
                led_q   <= nibble(pattern_d, last_q);
              end else begin
                step_q <= step_adv;
                led_q  <= nibble(pattern_d, step_adv);
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          HOLD: ;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    rdata = 32'b0;
    if (sel) begin
      case (addr)
        2'd0: rdata = {18'b0, step_q, 2'b0, done_q, (state_q == RUN),
                       2'b0, last_q, 2'b0, oneshot_q, en_q};
        2'd1: rdata[PERIOD_W-1:0] = period_q;
        2'd2: rdata[15:0] = pattern_q;
        default: rdata[3:0] = manual_q;
      endcase
    end
  end

  assign LED = led_q;
  assign irq = done_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer: a per-clock vector table plus hand-written
// sequences for the mid-run PERIOD change and the asynchronous reset.
module tb_led_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        rstrb, wstrb, sel;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0]  LED;
  logic        irq;

  int n_vec  = 0;
  int n_miss = 0;

  led_sequencer #(.PERIOD_W(24), .RESET_LED(4'b0000)) dut (
    .clk(clk), .reset(reset), .rstrb(rstrb), .wstrb(wstrb), .sel(sel),
    .addr(addr), .wdata(wdata), .rdata(rdata), .LED(LED), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic        rstrb;
    logic        wstrb;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  led;
    logic        irq;
    logic        chk_rd;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic s, input logic r, input logic w,
                              input logic [1:0] a, input logic [31:0] d,
                              input logic [3:0] led, input logic i,
                              input logic c, input logic [31:0] rd);
    vec_t v;
    v.sel = s; v.rstrb = r; v.wstrb = w; v.addr = a; v.wdata = d;
    v.led = led; v.irq = i; v.chk_rd = c; v.rd = rd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one set of bus inputs across a rising edge; return 1 time unit after it.
  task automatic drv(input logic s, input logic r, input logic w,
                     input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    sel = s; rstrb = r; wstrb = w; addr = a; wdata = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    sel = 1'b1; rstrb = 1'b0; wstrb = 1'b0; addr = 2'd0; wdata = 32'b0;
    #12;
    check("reset_led", {28'b0, LED}, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    check("reset_ctrl", rdata, 32'h0000_0030);
    @(negedge clk);
    reset = 1'b0;
    sel = 1'b0;

    tbl.push_back(mk(1,0,1,3,32'hA,     4'hA,0,1,32'h0000_000A)); // MANUAL=A
    tbl.push_back(mk(0,0,0,0,32'h0,     4'hA,0,1,32'h0));         // sel=0 -> rdata 0
    tbl.push_back(mk(1,1,0,0,32'h0,     4'hA,0,1,32'h0000_0030));
    tbl.push_back(mk(1,0,1,1,32'h2,     4'hA,0,1,32'h2));         // PERIOD=2
    tbl.push_back(mk(1,0,1,2,32'h4321,  4'hA,0,1,32'h4321));
    tbl.push_back(mk(1,0,1,0,32'h31,    4'h1,0,1,32'h131));       // loop start
    tbl.push_back(mk(0,0,0,0,32'h0,     4'h1,0,0,32'h0));
    tbl.push_back(mk(0,0,0,0,32'h0,     4'h1,0,0,32'h0));
    for (int k = 2; k <= 4; k++)
      for (int j = 0; j < 3; j++)
        tbl.push_back(mk(0,0,0,0,32'h0, 4'(k),0,0,32'h0));
    tbl.push_back(mk(1,1,0,0,32'h0,     4'h1,0,1,32'h131));       // wrap to step 0
    tbl.push_back(mk(1,0,1,0,32'h0,     4'hA,0,1,32'h0));         // stop -> MANUAL
    tbl.push_back(mk(1,0,1,1,32'h0,     4'hA,0,1,32'h0));         // PERIOD=0
    tbl.push_back(mk(1,0,1,0,32'h13,    4'h1,0,1,32'h113));       // one-shot LAST=1
    tbl.push_back(mk(0,0,0,0,32'h0,     4'h2,0,0,32'h0));
    tbl.push_back(mk(1,1,0,0,32'h0,     4'h2,1,1,32'h1212));      // DONE set vs read clear
    tbl.push_back(mk(0,0,0,0,32'h0,     4'h2,1,0,32'h0));
    tbl.push_back(mk(1,1,0,0,32'h0,     4'h2,0,1,32'h1012));      // read clears DONE
    tbl.push_back(mk(0,0,0,0,32'h0,     4'h2,0,0,32'h0));         // HOLD frozen
    tbl.push_back(mk(1,0,1,0,32'h0,     4'hA,0,1,32'h1000));      // HOLD -> IDLE

    for (int i = 0; i < tbl.size(); i++) begin
      drv(tbl[i].sel, tbl[i].rstrb, tbl[i].wstrb, tbl[i].addr, tbl[i].wdata);
      check($sformatf("v%0d_led", i), {28'b0, LED}, {28'b0, tbl[i].led});
      check($sformatf("v%0d_irq", i), {31'b0, irq}, {31'b0, tbl[i].irq});
      if (tbl[i].chk_rd)
        check($sformatf("v%0d_rdata", i), rdata, tbl[i].rd);
    end

    // Shrinking PERIOD mid-step ends the step on the following clock.
    drv(1,0,1,1,32'd100);
    drv(1,0,1,0,32'h31);
    check("mid_start_led", {28'b0, LED}, 32'h1);
    repeat (50) drv(0,0,0,0,32'h0);
    check("mid_cnt50_led", {28'b0, LED}, 32'h1);
    drv(1,0,1,1,32'd10);
    check("mid_wrperiod_led", {28'b0, LED}, 32'h1);
    drv(0,0,0,0,32'h0);
    check("mid_advance_led", {28'b0, LED}, 32'h2);
    drv(1,0,1,0,32'h0);
    check("mid_stop_led", {28'b0, LED}, 32'hA);
    check("mid_stop_busy", {31'b0, rdata[8]}, 32'h0);

    // Asynchronous reset in the middle of a run, between clock edges.
    drv(1,0,1,0,32'h31);
    repeat (15) drv(0,0,0,0,32'h0);
    check("prereset_led", {28'b0, LED}, 32'h2);
    #2;
    reset = 1'b1;
    sel = 1'b1; addr = 2'd0; rstrb = 1'b0; wstrb = 1'b0;
    #1;
    check("async_led", {28'b0, LED}, 32'h0);
    check("async_irq", {31'b0, irq}, 32'h0);
    check("async_ctrl", rdata, 32'h0000_0030);
    @(negedge clk);
    reset = 1'b0;
    sel = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
